// File: rtl/ppi_mux_pkg.sv
// Shared types and widths for the dual-channel ADC to PPI multiplexer.
`timescale 1ns/1ps
package ppi_mux_pkg;

    localparam int unsigned ADC_W = 13;
    localparam int unsigned PPI_W = 16;

    // Output word slot: idle, channel-1 word, channel-2 word
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        W1   = 2'd1,
        W2   = 2'd2
    } slot_t;

    // Two's complement sign extension of an ADC result to a PPI word
    function automatic logic [PPI_W-1:0] sign_ext(input logic [ADC_W-1:0] v);
        return {{(PPI_W-ADC_W){v[ADC_W-1]}}, v};
    endfunction

endpackage

// File: rtl/ppi_mux_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level with edge pulses.
// Ports: clk, rst_n (async active-low), din (async level),
//        level (synchronised level), rise_c/fall_c (one-cycle edge pulses).
`timescale 1ns/1ps
module ppi_mux_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] sr;
    logic              prev;

    // Synchroniser chain plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= '0;
            prev <= 1'b0;
        end else begin
            sr   <= (sr << 1) | STAGES'(din);
            prev <= sr[STAGES-1];
        end
    end

    assign level  = sr[STAGES-1];
    assign rise_c = level & ~prev;
    assign fall_c = ~level & prev;

endmodule

// File: rtl/ppi_mux.sv
// Dual-channel 13-bit ADC to 16-bit PPI multiplexer.
// Ports: CLK25M (clock), RESET_N (async active-low), MINS_CLK5 (word clock,
//        sampled), MINS_CLK2 (frame clock, sampled), start_adc (async enable),
//        data1/data2 (ADC results), dataout (PPI word), framesync (channel-1
//        slot marker), ppi_clk (PPI sample clock), adc_clk (ADC conversion clock).
`timescale 1ns/1ps
module ppi_mux
    import ppi_mux_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned PPI_CLK_DELAY = 1
) (
    input  logic             CLK25M,
    input  logic             RESET_N,
    input  logic             MINS_CLK5,
    input  logic             MINS_CLK2,
    input  logic             start_adc,
    input  logic [ADC_W-1:0] data1,
    input  logic [ADC_W-1:0] data2,
    output logic [PPI_W-1:0] dataout,
    output logic             framesync,
    output logic             ppi_clk,
    output logic             adc_clk
);

    logic c5_s, c5_rise, c5_fall;
    logic c2_s, c2_rise, c2_fall;
    logic start_s, start_rise, start_fall;
    logic unused_edges;

    ppi_mux_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_c5 (
        .clk(CLK25M), .rst_n(RESET_N), .din(MINS_CLK5),
        .level(c5_s), .rise_c(c5_rise), .fall_c(c5_fall)
    );

    ppi_mux_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_c2 (
        .clk(CLK25M), .rst_n(RESET_N), .din(MINS_CLK2),
        .level(c2_s), .rise_c(c2_rise), .fall_c(c2_fall)
    );

    ppi_mux_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_start (
        .clk(CLK25M), .rst_n(RESET_N), .din(start_adc),
        .level(start_s), .rise_c(start_rise), .fall_c(start_fall)
    );

    assign unused_edges = &{1'b0, c5_rise, start_rise, start_fall};

    logic             run;
    logic [ADC_W-1:0] cap1, cap2;
    logic             capture;

    assign capture = c2_fall & run;

    // run only changes on frame boundaries; capture mid-frame on the c2 fall
    always_ff @(posedge CLK25M or negedge RESET_N) begin
        if (!RESET_N) begin
            run     <= 1'b0;
            adc_clk <= 1'b0;
            cap1    <= '0;
            cap2    <= '0;
        end else begin
            if (c2_rise) begin
                run <= start_s;
            end
            adc_clk <= c2_s & run;
            if (capture) begin
                cap1 <= data1;
                cap2 <= data2;
            end
        end
    end

    // ppi_clk trails the synchronised word clock for data setup margin
    if (PPI_CLK_DELAY == 0) begin : g_ppi_nodly
        assign ppi_clk = c5_s;
    end else begin : g_ppi_dly
        logic [PPI_CLK_DELAY-1:0] dly;
        always_ff @(posedge CLK25M or negedge RESET_N) begin
            if (!RESET_N) begin
                dly <= '0;
            end else begin
                dly <= (dly << 1) | PPI_CLK_DELAY'(c5_s);
            end
        end
        assign ppi_clk = dly[PPI_CLK_DELAY-1];
    end

    slot_t            state, state_n;
    logic             pend, pend_n;
    logic [PPI_W-1:0] dataout_n;
    logic             framesync_n;

    // Slot FSM state and registered PPI outputs
    always_ff @(posedge CLK25M or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            pend      <= 1'b0;
            dataout   <= '0;
            framesync <= 1'b0;
        end else begin
            state     <= state_n;
            pend      <= pend_n;
            dataout   <= dataout_n;
            framesync <= framesync_n;
        end
    end

    // Advance one slot per word-clock fall; a pending capture starts a new W1
    always_comb begin
        state_n     = state;
        pend_n      = pend;
        dataout_n   = dataout;
        framesync_n = framesync;
        if (c5_fall) begin
            case (state)
                IDLE, W2: begin
                    if (pend) begin
                        state_n     = W1;
                        dataout_n   = sign_ext(cap1);
                        framesync_n = 1'b1;
                        pend_n      = 1'b0;
                    end else begin
                        state_n     = IDLE;
                        framesync_n = 1'b0;
                    end
                end
                W1: begin
                    state_n     = W2;
                    dataout_n   = sign_ext(cap2);
                    framesync_n = 1'b0;
                end
                default: begin
                    state_n     = IDLE;
                    framesync_n = 1'b0;
                end
            endcase
        end
        // A capture landing with a slot advance is kept for the next W1
        if (capture) begin
            pend_n = 1'b1;
        end
    end

endmodule

// File: tb/tb_ppi_mux.sv
// Self-checking bench for ppi_mux: drives the word/frame clocks and ADC data,
// predicts the PPI word stream per frame and checks it at every ppi_clk rise.
`timescale 1ns/1ps
module tb_ppi_mux;

    localparam real HALF   = 97.65625;
    localparam int  NR     = 104;
    localparam int  RST_N  = 68;
    localparam int  REL_N  = 69;

    logic        CLK25M;
    logic        RESET_N;
    logic        MINS_CLK5;
    logic        MINS_CLK2;
    logic        start_adc;
    logic [12:0] data1;
    logic [12:0] data2;
    logic [15:0] dataout;
    logic        framesync;
    logic        ppi_clk;
    logic        adc_clk;

    ppi_mux #(.SYNC_STAGES(2), .PPI_CLK_DELAY(1)) dut (
        .CLK25M(CLK25M), .RESET_N(RESET_N), .MINS_CLK5(MINS_CLK5),
        .MINS_CLK2(MINS_CLK2), .start_adc(start_adc), .data1(data1),
        .data2(data2), .dataout(dataout), .framesync(framesync),
        .ppi_clk(ppi_clk), .adc_clk(adc_clk)
    );

    initial begin
        CLK25M = 1'b0;
        forever #20 CLK25M = ~CLK25M;
    end

    typedef struct {
        int          idx;
        logic [15:0] w;
        logic        fs;
    } wexp_t;

    wexp_t       q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_latest = -1;
    int          prev_m = -1;
    logic [15:0] last_word = 16'h0;
    real         t_chg = 0.0;
    real         t_fs = -1.0;
    bit          cur_run = 1'b0;

    function automatic logic [15:0] sx(input logic [12:0] v);
        return {{3{v[12]}}, v};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    always @(dataout or framesync) t_chg = $realtime;

    // framesync period while streaming: one frame, within one CLK25M cycle
    always @(posedge framesync) begin
        if (t_fs >= 0.0 && ($realtime - t_fs) < 600.0) begin
            checks++;
            if (($realtime - t_fs) < 390.625 - 40.0 || ($realtime - t_fs) > 390.625 + 40.0) begin
                errors++;
                $display("FAIL fs_period: got %0.3f ns expected 390.625 +/- 40", $realtime - t_fs);
            end
        end
        t_fs = $realtime;
    end

    // Word stream compare at each PPI sample edge
    always @(posedge ppi_clk) begin
        int  m;
        bit  sched;
        real setup;
        logic ex_fs;
        setup = $realtime - t_chg;
        #1;
        m     = n_latest;
        sched = 1'b0;
        ex_fs = 1'b0;
        if (prev_m >= 0) chk("ppi_rate", 32'(m), 32'(prev_m + 1));
        prev_m = m;
        while (q.size() > 0 && q[0].idx < m) begin
            chk("word_missed", 32'(m), 32'(q[0].idx));
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].idx == m) begin
            last_word = q[0].w;
            ex_fs     = q[0].fs;
            sched     = 1'b1;
            void'(q.pop_front());
        end
        chk("dataout", 32'(dataout), 32'(last_word));
        chk("framesync", 32'(framesync), 32'(ex_fs));
        if (sched) begin
            checks++;
            if (setup < 79.0) begin
                errors++;
                $display("FAIL setup: got %0.3f ns expected >= 80 ns", setup);
            end
        end
        case (m)
            8:  chk("pin_f666", 32'(dataout), 32'h0000F666);
            9:  chk("pin_0999", 32'(dataout), 32'h00000999);
            10: chk("pin_0000", 32'(dataout), 32'h00000000);
            11: chk("pin_ffff", 32'(dataout), 32'h0000FFFF);
            12: chk("pin_feee", 32'(dataout), 32'h0000FEEE);
            13: chk("pin_0111", 32'(dataout), 32'h00000111);
            default: ;
        endcase
    end

    initial begin
        logic [12:0] fd1;
        logic [12:0] fd2;
        RESET_N   = 1'b0;
        MINS_CLK5 = 1'b0;
        MINS_CLK2 = 1'b0;
        start_adc = 1'b0;
        data1     = 13'h0;
        data2     = 13'h0;
        fd1       = 13'h0;
        fd2       = 13'h0;
        #103;
        chk("rst_dataout", 32'(dataout), 32'h0);
        chk("rst_framesync", 32'(framesync), 32'h0);
        chk("rst_ppi_clk", 32'(ppi_clk), 32'h0);
        chk("rst_adc_clk", 32'(adc_clk), 32'h0);

        for (int n = 0; n < NR; n++) begin
            // Word-clock rise; even rises are frame starts
            if (n % 2 == 0) begin
                int f;
                f = n / 2;
                chk("adc_clk_low", 32'(adc_clk), 32'h0);
                case (f)
                    3: begin fd1 = 13'h1666; fd2 = 13'h0999; end
                    4: begin fd1 = 13'h0000; fd2 = 13'h1FFF; end
                    5: begin fd1 = 13'h1EEE; fd2 = 13'h0111; end
                    default: begin
                        fd1 = 13'($urandom_range(0, 8191));
                        fd2 = 13'($urandom_range(0, 8191));
                    end
                endcase
                cur_run = RESET_N && start_adc;
                if (cur_run) begin
                    q.push_back('{idx: 2 * f + 2, w: sx(fd1), fs: 1'b1});
                    q.push_back('{idx: 2 * f + 3, w: sx(fd2), fs: 1'b0});
                end
                MINS_CLK2 = 1'b1;
            end else begin
                chk("adc_clk_run", 32'(adc_clk), 32'(cur_run));
                MINS_CLK2 = 1'b0;
            end
            MINS_CLK5 = 1'b1;
            n_latest  = n;
            if (n == 1 || n == REL_N) begin
                #40;
                RESET_N = 1'b1;
                #(HALF - 40.0);
            end else begin
                #(HALF);
            end

            // Word-clock fall
            MINS_CLK5 = 1'b0;
            if (n % 2 == 0) begin
                data1 = fd1;
                data2 = fd2;
            end
            if (n == 5)  start_adc = 1'b1;
            if (n == 50) start_adc = 1'b0;
            if (n == 59) start_adc = 1'b1;
            if (n >= 80 && n < 96 && n % 2 == 1) start_adc = ($urandom % 4) != 0;
            if (n == 97) start_adc = 1'b0;
            if (n == RST_N) begin
                #30;
                chk("fs_before_rst", 32'(framesync), 32'h1);
                RESET_N = 1'b0;
                q.delete();
                cur_run   = 1'b0;
                prev_m    = -1;
                t_fs      = -1.0;
                last_word = 16'h0;
                #1;
                chk("midrst_dataout", 32'(dataout), 32'h0);
                chk("midrst_framesync", 32'(framesync), 32'h0);
                chk("midrst_ppi_clk", 32'(ppi_clk), 32'h0);
                chk("midrst_adc_clk", 32'(adc_clk), 32'h0);
                #(HALF - 31.0);
            end else begin
                #(HALF);
            end
        end

        #300;
        chk("drain", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
